// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, position codes, board FSM states
// and board indexing helpers used by the checker and board owner.
package ttt_pkg;

    typedef enum logic [1:0] {
        CELL_BLANK = 2'b00,
        CELL_HUMAN = 2'b01,
        CELL_AI    = 2'b10
    } cell_t;

    typedef enum logic [3:0] {
        POS_NONE = 4'd0,
        POS_A = 4'd1, POS_B = 4'd2, POS_C = 4'd3,
        POS_D = 4'd4, POS_E = 4'd5, POS_F = 4'd6,
        POS_G = 4'd7, POS_H = 4'd8, POS_I = 4'd9
    } pos_t;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_COMMIT = 2'd1,
        S_CHECK  = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    localparam logic [3:0] MAX_MOVES = 4'd9;

    function automatic logic pos_valid(input logic [3:0] pos);
        return (pos >= POS_A) && (pos <= POS_I);
    endfunction

    // Board is {top, middle, bottom}; cell index 0 (a) sits in the top-left bits.
    function automatic logic [4:0] cell_lsb(input logic [3:0] idx);
        return 5'd16 - {idx, 1'b0};
    endfunction

    function automatic logic [1:0] board_cell(input logic [17:0] b, input logic [3:0] idx);
        return b[cell_lsb(idx) +: 2];
    endfunction

    function automatic logic three_equal(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c);
        return (a != CELL_BLANK) && (a == b) && (b == c);
    endfunction

endpackage

// File: rtl/win_line_detector.sv
// Combinational three-in-a-row detector over the 8 lines of the board;
// reports the winning mark (lowest-numbered line wins if several are hit).
module win_line_detector
    import ttt_pkg::*;
(
    input  logic [5:0] top,
    input  logic [5:0] middle,
    input  logic [5:0] bottom,
    output logic       win,
    output logic [1:0] win_mark
);

    logic [17:0] w_board;
    logic [1:0]  w_cell [0:8];
    logic [7:0]  w_hit;
    logic [1:0]  w_line_mark [0:7];

    assign w_board = {top, middle, bottom};

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cells
            assign w_cell[gi] = w_board[17-2*gi -: 2];
        end
        // Lines 0..2 are rows, 3..5 are columns.
        for (gi = 0; gi < 3; gi++) begin : g_lines
            assign w_hit[gi]         = three_equal(w_cell[3*gi], w_cell[3*gi+1], w_cell[3*gi+2]);
            assign w_line_mark[gi]   = w_cell[3*gi];
            assign w_hit[gi+3]       = three_equal(w_cell[gi], w_cell[gi+3], w_cell[gi+6]);
            assign w_line_mark[gi+3] = w_cell[gi];
        end
    endgenerate

    assign w_hit[6]       = three_equal(w_cell[0], w_cell[4], w_cell[8]);
    assign w_line_mark[6] = w_cell[4];
    assign w_hit[7]       = three_equal(w_cell[2], w_cell[4], w_cell[6]);
    assign w_line_mark[7] = w_cell[4];

    always_comb begin
        win      = |w_hit;
        win_mark = CELL_BLANK;
        for (int k = 7; k >= 0; k--) begin
            if (w_hit[k]) win_mark = w_line_mark[k];
        end
    end

endmodule

// File: rtl/board_state_update.sv
// Board-state owner: commits validated moves, alternates turns, counts moves and
// declares game over. Define WIN_DETECT_EN to add three-in-a-row win detection.
module board_state_update
    import ttt_pkg::*;
#(
    parameter logic HUMAN_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_move,
    input  logic [3:0] move_out,
    input  logic       new_game,
    output logic [5:0] top,
    output logic [5:0] middle,
    output logic [5:0] bottom,
    output logic       human_turn,
    output logic       commit_ack,
    output logic       illegal_write,
    output logic [3:0] move_count,
    output logic       game_over,
    output logic [1:0] winner
);

    state_t      r_state;
    state_t      w_state_next;
    logic [17:0] r_board;
    logic [3:0]  r_pos;
    logic [3:0]  r_move_count;
    logic        r_human_turn;
    logic        r_commit_ack;
    logic        r_illegal_write;
    logic        r_valid_prev;

    logic        w_accept;
    logic        w_cell_blank;
    logic [4:0]  w_lsb;
    logic [1:0]  w_mark;
    logic        w_write;
    logic        w_illegal;
    logic        w_toggle;
    logic        w_enter_over;
    logic        w_over;
    logic        w_win;

    assign w_lsb        = cell_lsb(r_pos - 4'd1);
    assign w_cell_blank = (board_cell(r_board, r_pos - 4'd1) == CELL_BLANK);
    assign w_mark       = r_human_turn ? CELL_HUMAN : CELL_AI;
    assign w_over       = (r_move_count == MAX_MOVES) || w_win;

`ifdef WIN_DETECT_EN
    logic [1:0] w_win_mark;
    logic [1:0] r_winner;

    win_line_detector u_win (
        .top      (r_board[17:12]),
        .middle   (r_board[11:6]),
        .bottom   (r_board[5:0]),
        .win      (w_win),
        .win_mark (w_win_mark)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             r_winner <= CELL_BLANK;
        else if (new_game)     r_winner <= CELL_BLANK;
        else if (w_enter_over) r_winner <= w_win_mark;
    end

    assign winner = r_winner;
`else
    assign w_win  = 1'b0;
    assign winner = 2'b00;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_state <= S_WAIT;
        else if (new_game) r_state <= S_WAIT;
        else               r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAIT:   if (w_accept) w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = w_cell_blank ? S_CHECK : S_WAIT;
            S_CHECK:  w_state_next = w_over ? S_OVER : S_WAIT;
            S_OVER:   w_state_next = S_OVER;
            default:  w_state_next = S_WAIT;
        endcase
    end

    // Accept only on a rising edge of valid_move so a held level commits once.
    always_comb begin
        w_accept     = (r_state == S_WAIT) && valid_move && !r_valid_prev && pos_valid(move_out);
        w_write      = (r_state == S_COMMIT) && w_cell_blank;
        w_illegal    = (r_state == S_COMMIT) && !w_cell_blank;
        w_toggle     = (r_state == S_CHECK) && !w_over;
        w_enter_over = (r_state == S_CHECK) && w_over;
        game_over    = (r_state == S_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || new_game) begin
            r_board         <= '0;
            r_pos           <= POS_NONE;
            r_move_count    <= 4'd0;
            r_human_turn    <= HUMAN_FIRST;
            r_commit_ack    <= 1'b0;
            r_illegal_write <= 1'b0;
            r_valid_prev    <= 1'b0;
        end else begin
            r_valid_prev    <= valid_move;
            r_commit_ack    <= w_write;
            r_illegal_write <= w_illegal;
            if (w_accept) r_pos <= move_out;
            if (w_write) begin
                r_board[w_lsb +: 2] <= w_mark;
                if (r_move_count != MAX_MOVES) r_move_count <= r_move_count + 4'd1;
            end
            if (w_toggle) r_human_turn <= ~r_human_turn;
        end
    end

    assign top           = r_board[17:12];
    assign middle        = r_board[11:6];
    assign bottom        = r_board[5:0];
    assign human_turn    = r_human_turn;
    assign commit_ack    = r_commit_ack;
    assign illegal_write = r_illegal_write;
    assign move_count    = r_move_count;

endmodule

// File: tb/tb_board_state_update.sv
// Directed bench for board_state_update; expectations follow the WIN_DETECT_EN build setting.
`timescale 1ns/1ps
module tb_board_state_update;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_move;
    logic [3:0] move_out;
    logic       new_game;
    logic [5:0] top, middle, bottom;
    logic       human_turn, commit_ack, illegal_write, game_over;
    logic [3:0] move_count;
    logic [1:0] winner;

    int n_vec = 0;
    int n_err = 0;
    int ack_cnt;
    logic saw_ack, saw_ill;

    board_state_update #(.HUMAN_FIRST(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_move    (valid_move),
        .move_out      (move_out),
        .new_game      (new_game),
        .top           (top),
        .middle        (middle),
        .bottom        (bottom),
        .human_turn    (human_turn),
        .commit_ack    (commit_ack),
        .illegal_write (illegal_write),
        .move_count    (move_count),
        .game_over     (game_over),
        .winner        (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pulsed move: accept edge, commit edge, check edge.
    task automatic play(input logic [3:0] pos);
        valid_move = 1'b1;
        move_out   = pos;
        tick();
        valid_move = 1'b0;
        tick();
        saw_ack = commit_ack;
        saw_ill = illegal_write;
        tick();
        $display("move %0d: ack=%0b ill=%0b count=%0d turn=%0b over=%0b winner=%0d rows=%b_%b_%b",
                 pos, saw_ack, saw_ill, move_count, human_turn, game_over, winner, top, middle, bottom);
    endtask

    task automatic start_new();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    initial begin
        reset = 1'b1; valid_move = 1'b0; move_out = 4'd0; new_game = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_rows",  {top, middle, bottom}, 18'd0);
        check("rst_count", move_count, 4'd0);
        check("rst_turn",  human_turn, 1'b1);
        check("rst_over",  game_over, 1'b0);
        check("rst_win",   winner, 2'b00);
        check("rst_pulse", {commit_ack, illegal_write}, 2'b00);

        // Level-held valid_move on centre: one commit only.
        valid_move = 1'b1; move_out = 4'd5; ack_cnt = 0;
        tick(); ack_cnt += int'(commit_ack);
        tick(); ack_cnt += int'(commit_ack);
        check("hold_turn_1cyc", human_turn, 1'b1);
        tick(); ack_cnt += int'(commit_ack);
        check("hold_turn_2cyc", human_turn, 1'b0);
        tick(); ack_cnt += int'(commit_ack);
        valid_move = 1'b0;
        tick();
        $display("held move 5: acks=%0d count=%0d middle=%b", ack_cnt, move_count, middle);
        check("hold_middle", middle, 6'b000100);
        check("hold_acks",   ack_cnt, 1);
        check("hold_count",  move_count, 4'd1);

        // Out-of-range codes are ignored.
        play(4'd0);
        check("code0_ack", saw_ack, 1'b0);
        play(4'd12);
        check("code12_ack", saw_ack, 1'b0);
        check("codes_count", move_count, 4'd1);

        // Illegal write onto an occupied cell.
        start_new();
        play(4'd1);
        check("ill_first_ack", saw_ack, 1'b1);
        play(4'd1);
        check("ill_pulse", saw_ill, 1'b1);
        check("ill_noack", saw_ack, 1'b0);
        check("ill_top",   top, 6'b010000);
        check("ill_count", move_count, 4'd1);
        check("ill_turn",  human_turn, 1'b0);

        // Human wins the top row on move 5.
        start_new();
        play(4'd1); play(4'd4); play(4'd2); play(4'd5); play(4'd3);
        check("win_top",    top, 6'b010101);
        check("win_middle", middle, 6'b101000);
`ifdef WIN_DETECT_EN
        check("win_winner", winner, 2'b01);
        check("win_over",   game_over, 1'b1);
        play(4'd6);
        check("win_frozen_ack",   saw_ack, 1'b0);
        check("win_frozen_count", move_count, 4'd5);
        check("win_frozen_mid",   middle, 6'b101000);
`else
        check("win_nodet_over", game_over, 1'b0);
        check("win_nodet_turn", human_turn, 1'b0);
        play(4'd6); play(4'd7); play(4'd8); play(4'd9);
        check("win_nodet_count",  move_count, 4'd9);
        check("win_nodet_full",   game_over, 1'b1);
        check("win_nodet_winner", winner, 2'b00);
`endif

        // Draw: full board, no winner.
        start_new();
        play(4'd1); play(4'd2); play(4'd3); play(4'd5); play(4'd4);
        play(4'd6); play(4'd8); play(4'd7); play(4'd9);
        check("draw_rows",   {top, middle, bottom}, {6'b011001, 6'b011010, 6'b100101});
        check("draw_count",  move_count, 4'd9);
        check("draw_over",   game_over, 1'b1);
        check("draw_winner", winner, 2'b00);
        play(4'd5);
        check("draw_frozen_ack",   saw_ack, 1'b0);
        check("draw_frozen_count", move_count, 4'd9);

        // new_game coincident with the accept of move 7.
        start_new();
        play(4'd1); play(4'd2); play(4'd3); play(4'd5); play(4'd4); play(4'd6);
        check("ng_pre_count", move_count, 4'd6);
        valid_move = 1'b1; move_out = 4'd8; new_game = 1'b1;
        tick();
        valid_move = 1'b0; new_game = 1'b0;
        check("ng_rows",  {top, middle, bottom}, 18'd0);
        check("ng_count", move_count, 4'd0);
        check("ng_turn",  human_turn, 1'b1);
        tick();
        check("ng_noack", commit_ack, 1'b0);
        tick();
        check("ng_rows_later", {top, middle, bottom}, 18'd0);
        $display("new_game with move 8: count=%0d rows=%b_%b_%b", move_count, top, middle, bottom);

        // Reset asserted while in COMMIT.
        start_new();
        play(4'd1);
        valid_move = 1'b1; move_out = 4'd5;
        tick();
        reset = 1'b1;
        #2;
        check("rc_rows_async", {top, middle, bottom}, 18'd0);
        check("rc_count",      move_count, 4'd0);
        valid_move = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        check("rc_noack", commit_ack, 1'b0);
        check("rc_rows",  {top, middle, bottom}, 18'd0);
        check("rc_turn",  human_turn, 1'b1);
        play(4'd5);
        check("rc_wait_ack",    saw_ack, 1'b1);
        check("rc_wait_middle", middle, 6'b000100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
